// File: rtl/vending_fsm_multi.sv
// vending_fsm_multi: coin credit, drink vend and change controller (coins/keypad in; total_coin, avail_mask, vend_*, change_*, coin_reject, sel_error, busy out)
module vending_fsm_multi #(
  parameter int NUM_DRINKS = 4,
  parameter int CREDIT_W = 8,
  parameter int MAX_CREDIT = 200,
  parameter logic [NUM_DRINKS*CREDIT_W-1:0] PRICES = {8'd40, 8'd30, 8'd25, 8'd15},
  localparam int SW = $clog2(NUM_DRINKS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  coin_valid,
  input  logic [7:0]            coin_value,
  input  logic                  sel_valid,
  input  logic [SW-1:0]         drink_sel,
  input  logic                  cancel,
  output logic [CREDIT_W-1:0]   total_coin,
  output logic [NUM_DRINKS-1:0] avail_mask,
  output logic                  coin_reject,
  output logic                  sel_error,
  output logic                  vend_valid,
  output logic [SW-1:0]         vend_drink,
  output logic                  change_valid,
  output logic [7:0]            change_coin,
  output logic                  busy
);
  typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;
  state_t state, state_n;
  logic [CREDIT_W-1:0] total_n, price;
  logic [CREDIT_W:0] sum;
  logic [7:0] den, change_coin_n;
  logic [SW-1:0] idx, vend_drink_n;
  logic sel_ok, coin_ok, coin_reject_n, sel_error_n, vend_valid_n, change_valid_n;
  assign sel_ok = 32'(drink_sel) < NUM_DRINKS;
  assign idx = sel_ok ? drink_sel : '0;
  assign price = PRICES[32'(idx)*CREDIT_W +: CREDIT_W];
  assign sum = {1'b0, total_coin} + (CREDIT_W+1)'(coin_value);
  assign coin_ok = coin_value inside {8'd1, 8'd5, 8'd10, 8'd50} && sum <= (CREDIT_W+1)'(MAX_CREDIT);
  assign den = total_coin >= CREDIT_W'(50) ? 8'd50 : total_coin >= CREDIT_W'(10) ? 8'd10 :
               total_coin >= CREDIT_W'(5) ? 8'd5 : 8'd1;
  assign busy = state != COLLECT;
  for (genvar i = 0; i < NUM_DRINKS; i++)
    assign avail_mask[i] = state == COLLECT && PRICES[i*CREDIT_W +: CREDIT_W] <= total_coin;
  always_comb begin
    state_n = state;
    total_n = total_coin;
    coin_reject_n = 1'b0;
    sel_error_n = 1'b0;
    vend_valid_n = 1'b0;
    vend_drink_n = '0;
    change_valid_n = 1'b0;
    change_coin_n = '0;
    case (state)
      COLLECT:
        if (cancel) begin
          coin_reject_n = coin_valid;
          state_n = total_coin != '0 ? CHANGE : COLLECT;
        end else if (sel_valid) begin
          coin_reject_n = coin_valid;
          if (sel_ok && price <= total_coin) begin
            state_n = VEND;
            vend_valid_n = 1'b1;
            vend_drink_n = drink_sel;
            total_n = total_coin - price;
          end else sel_error_n = 1'b1;
        end else if (coin_valid) begin
          coin_reject_n = !coin_ok;
          total_n = coin_ok ? sum[CREDIT_W-1:0] : total_coin;
        end
      VEND: begin
        coin_reject_n = coin_valid;
        state_n = total_coin != '0 ? CHANGE : COLLECT;
      end
      CHANGE: begin
        coin_reject_n = coin_valid;
        state_n = total_coin == '0 ? COLLECT : CHANGE;
        change_valid_n = total_coin != '0;
        change_coin_n = total_coin != '0 ? den : 8'd0;
        total_n = total_coin != '0 ? total_coin - CREDIT_W'(den) : total_coin;
      end
      default: state_n = COLLECT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= COLLECT;
      total_coin <= '0;
      coin_reject <= 1'b0;
      sel_error <= 1'b0;
      vend_valid <= 1'b0;
      vend_drink <= '0;
      change_valid <= 1'b0;
      change_coin <= '0;
    end else begin
      state <= state_n;
      total_coin <= total_n;
      coin_reject <= coin_reject_n;
      sel_error <= sel_error_n;
      vend_valid <= vend_valid_n;
      vend_drink <= vend_drink_n;
      change_valid <= change_valid_n;
      change_coin <= change_coin_n;
    end
  end
endmodule

// File: tb/tb_vending_fsm_multi.sv
// tb_vending_fsm_multi: directed self-checking bench for vending_fsm_multi (4-drink and 3-drink builds)
module tb_vending_fsm_multi;
  logic clk = 0, reset = 1;
  logic coin_valid = 0, sel_valid = 0, cancel = 0;
  logic [7:0] coin_value = 0;
  logic [1:0] drink_sel = 0;
  logic [7:0] total_coin, change_coin;
  logic [3:0] avail_mask;
  logic [1:0] vend_drink;
  logic coin_reject, sel_error, vend_valid, change_valid, busy;
  logic sel_valid3 = 0;
  logic [1:0] drink_sel3 = 0;
  logic [7:0] total_coin3, change_coin3;
  logic [2:0] avail_mask3;
  logic [1:0] vend_drink3;
  logic coin_reject3, sel_error3, vend_valid3, change_valid3, busy3;
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  vending_fsm_multi dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .drink_sel(drink_sel), .cancel(cancel),
    .total_coin(total_coin), .avail_mask(avail_mask), .coin_reject(coin_reject),
    .sel_error(sel_error), .vend_valid(vend_valid), .vend_drink(vend_drink),
    .change_valid(change_valid), .change_coin(change_coin), .busy(busy)
  );
  vending_fsm_multi #(.NUM_DRINKS(3), .PRICES({8'd30, 8'd25, 8'd15})) dut3 (
    .clk(clk), .reset(reset), .coin_valid(1'b0), .coin_value(8'd0),
    .sel_valid(sel_valid3), .drink_sel(drink_sel3), .cancel(1'b0),
    .total_coin(total_coin3), .avail_mask(avail_mask3), .coin_reject(coin_reject3),
    .sel_error(sel_error3), .vend_valid(vend_valid3), .vend_drink(vend_drink3),
    .change_valid(change_valid3), .change_coin(change_coin3), .busy(busy3)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    coin_valid = 0;
    sel_valid = 0;
    cancel = 0;
    sel_valid3 = 0;
  endtask
  task automatic coin(input logic [7:0] v);
    coin_valid = 1;
    coin_value = v;
    tick();
  endtask
  task automatic sel(input logic [1:0] d);
    sel_valid = 1;
    drink_sel = d;
    tick();
  endtask
  task automatic chg(input string tag, input int c, input int t);
    tick();
    chk({tag, "_cv"}, change_valid, 1);
    chk({tag, "_coin"}, change_coin, c);
    chk({tag, "_total"}, total_coin, t);
  endtask
  initial begin
    tick();
    tick();
    reset = 0;
    chk("rst_total", total_coin, 0);
    chk("rst_avail", avail_mask, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vend", vend_valid, 0);
    chk("rst_cv", change_valid, 0);
    chk("rst_total3", total_coin3, 0);
    coin(10);
    chk("c10_total", total_coin, 10);
    chk("c10_rej", coin_reject, 0);
    coin(10);
    coin(5);
    chk("c25_total", total_coin, 25);
    chk("c25_avail", avail_mask, 4'b0011);
    sel(1);
    chk("v1_valid", vend_valid, 1);
    chk("v1_drink", vend_drink, 1);
    chk("v1_total", total_coin, 0);
    chk("v1_busy", busy, 1);
    chk("v1_avail", avail_mask, 0);
    tick();
    chk("v1_done_busy", busy, 0);
    chk("v1_done_cv", change_valid, 0);
    chk("v1_done_vend", vend_valid, 0);
    coin(50);
    coin(1);
    chk("c51_total", total_coin, 51);
    chk("c51_avail", avail_mask, 4'b1111);
    sel(3);
    chk("v3_valid", vend_valid, 1);
    chk("v3_drink", vend_drink, 3);
    chk("v3_total", total_coin, 11);
    coin(10);
    chk("vend_coin_rej", coin_reject, 1);
    chk("vend_coin_total", total_coin, 11);
    chk("v3_chg_enter_cv", change_valid, 0);
    chk("v3_chg_enter_busy", busy, 1);
    chg("v3_chg10", 10, 1);
    chg("v3_chg1", 1, 0);
    tick();
    chk("v3_end_cv", change_valid, 0);
    chk("v3_end_busy", busy, 0);
    for (int i = 0; i < 4; i++) coin(50);
    chk("c200_total", total_coin, 200);
    chk("c200_rej", coin_reject, 0);
    coin(1);
    chk("over_rej", coin_reject, 1);
    chk("over_total", total_coin, 200);
    coin(7);
    chk("bad_rej", coin_reject, 1);
    chk("bad_total", total_coin, 200);
    cancel = 1;
    tick();
    for (int i = 0; i < 4; i++) chg("r200", 50, 150 - 50 * i);
    tick();
    chk("r200_busy", busy, 0);
    coin(10);
    coin(10);
    sel(2);
    sel_valid3 = 1;
    drink_sel3 = 3;
    chk("se2_err", sel_error, 1);
    chk("se2_vend", vend_valid, 0);
    chk("se2_total", total_coin, 20);
    chk("se2_busy", busy, 0);
    tick();
    chk("se2_err_pulse", sel_error, 0);
    chk("oor_err", sel_error3, 1);
    chk("oor_vend", vend_valid3, 0);
    cancel = 1;
    tick();
    chg("r20a", 10, 10);
    chg("r20b", 10, 0);
    tick();
    chk("r20_busy", busy, 0);
    coin(50);
    coin(10);
    coin(5);
    coin(1);
    chk("c66_total", total_coin, 66);
    cancel = 1;
    sel_valid = 1;
    drink_sel = 0;
    coin_valid = 1;
    coin_value = 10;
    tick();
    chk("cx_rej", coin_reject, 1);
    chk("cx_vend", vend_valid, 0);
    chk("cx_err", sel_error, 0);
    chk("cx_busy", busy, 1);
    chk("cx_total", total_coin, 66);
    chg("cx50", 50, 16);
    chg("cx10", 10, 6);
    chg("cx5", 5, 1);
    chg("cx1", 1, 0);
    tick();
    chk("cx_end_cv", change_valid, 0);
    chk("cx_end_busy", busy, 0);
    coin(50);
    coin(10);
    coin(5);
    coin(1);
    cancel = 1;
    tick();
    chg("rs50", 50, 16);
    reset = 1;
    tick();
    reset = 0;
    chk("rs_total", total_coin, 0);
    chk("rs_cv", change_valid, 0);
    chk("rs_busy", busy, 0);
    coin(5);
    chk("rs_after_total", total_coin, 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/vending_fsm_multi.md
Name: vending_fsm_multi

Overview:
Parametrised vending-machine controller, successor to the fixed 2-bit-state drink FSM. Accumulates validated coins into a credit register and reports which drinks are affordable. Accepts a drink selection, vends it and returns the remaining credit as change, one coin per cycle. Cancel refunds the full credit. Sits between the coin acceptor/keypad front end and the dispenser/change hopper.

Parameters:
NUM_DRINKS, 4, number of drink channels (2..16)
CREDIT_W, 8, width of credit register total_coin
MAX_CREDIT, 200, maximum credit held; coins that would exceed it are rejected
PRICES, {8'd40,8'd30,8'd25,8'd15}, packed CREDIT_W-bit price table; drink i price = PRICES[i*CREDIT_W +: CREDIT_W] (drink0=15, drink1=25, drink2=30, drink3=40)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
coin_valid  in  1  one-cycle strobe, coin present on coin_value
coin_value  in  8  coin denomination
sel_valid  in  1  one-cycle strobe, selection present on drink_sel
drink_sel  in  $clog2(NUM_DRINKS)  drink index
cancel  in  1  refund request strobe
total_coin  out  CREDIT_W  current credit
avail_mask  out  NUM_DRINKS  bit i = 1 when PRICES[i] <= total_coin and state is COLLECT
coin_reject  out  1  one-cycle pulse, coin refused
sel_error  out  1  one-cycle pulse, selection refused
vend_valid  out  1  one-cycle pulse, dispense drink
vend_drink  out  $clog2(NUM_DRINKS)  drink being dispensed, valid with vend_valid
change_valid  out  1  one coin released this cycle
change_coin  out  8  denomination released, valid with change_valid
busy  out  1  high in VEND and CHANGE

Behaviour:
- Reset (synchronous, active-high, checked every edge, overrides everything including mid-vend/mid-change): state=COLLECT, total_coin=0; all pulse outputs, vend_drink and change_coin = 0. No pending change is preserved.
- States: COLLECT, VEND, CHANGE. All outputs registered; pulses assert in the cycle after the triggering input edge.
- COLLECT, per-cycle priority: cancel > sel_valid > coin_valid. Lower-priority inputs in the same cycle are dropped silently, except a dropped coin pulses coin_reject.
- Coin in COLLECT: the accepted denominations are 1, 5, 10 and 50. Any other value pulses coin_reject. A coin for which total_coin+coin_value > MAX_CREDIT also pulses coin_reject. Rejected coins leave the credit unchanged. An accepted coin updates total_coin by the next edge. The sum is computed at CREDIT_W+1 bits, so there is no wrap.
- Selection in COLLECT: if drink_sel >= NUM_DRINKS or the price exceeds total_coin, pulse sel_error and stay in COLLECT. Otherwise go to VEND.
- VEND, exactly 1 cycle: vend_valid=1, vend_drink=selection, total_coin -= price. Next state is CHANGE if the remainder is > 0, else COLLECT.
- Cancel in COLLECT: if total_coin > 0, go to CHANGE. If total_coin == 0, it is a no-op.
- CHANGE: each cycle, release the largest denomination from {50,10,5,1} that is <= total_coin. Drive change_valid=1 and change_coin=denomination, and subtract it from total_coin. When total_coin reaches 0, return to COLLECT; change_valid is low in that cycle.
- In VEND/CHANGE, coin_valid pulses coin_reject, and sel_valid and cancel are ignored (no sel_error).
- avail_mask is 0 outside COLLECT.
- Invariant: total_coin <= MAX_CREDIT at all times.

Test Plan:
- Reset, then coins 10,10,5 -> total_coin=25; avail_mask=4'b0011; sel drink1 -> vend_valid with vend_drink=1, total 0, no change_valid, back to COLLECT.
- Coins 50,1 (51), sel drink3 -> vend drink3, then change 10 and 1 on consecutive cycles, total 0, COLLECT.
- Coin 50 x4 = 200, then coin 1 -> coin_reject, total stays 200. Coin value 7 -> coin_reject.
- Credit 20, sel drink2 -> sel_error, total 20. Sel index out of range (NUM_DRINKS=3 build) -> sel_error.
- Credit 66, cancel together with sel_valid and coin_valid -> refund 50,10,5,1 over 4 cycles. The coin gets coin_reject. No vend.
- Reset asserted during the second CHANGE cycle -> next cycle total_coin=0, state COLLECT, change_valid=0.
